// File: rtl/csa_share_sched.sv
// csa_share_sched: round-robin sharing of one 4-bit carry-skip adder slice
// between two requesters, summing WIDTH-bit operands one nibble per cycle.
module csa4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] c;
  always_comb begin
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
    end
    // all-propagate nibble lets cin bypass the ripple chain
    cout = &(a ^ b) ? cin : c[4];
  end
endmodule

module csa_share_sched #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             busy
);
  localparam int NIB = WIDTH / 4;
  localparam int KW  = NIB > 1 ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, ADD, RESP} state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             cin_q, cin_d, id_q, id_d, carry_q, carry_d, prio_q, prio_d;
  logic             g1, ad_cin, ad_c;
  logic [3:0]       ad_s;

  assign ad_cin = k_q == '0 ? cin_q : carry_q;

  csa4 u_csa (.a(a_q[4*k_q +: 4]), .b(b_q[4*k_q +: 4]), .cin(ad_cin), .s(ad_s), .cout(ad_c));

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    a_d        = a_q;
    b_d        = b_q;
    cin_d      = cin_q;
    id_d       = id_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    prio_d     = prio_q;
    g1         = req1_valid && (!req0_valid || prio_q);
    req0_ready = state_q == IDLE && req0_valid && !g1;
    req1_ready = state_q == IDLE && g1;
    case (state_q)
      IDLE: if (req0_ready || req1_ready) begin
        a_d     = g1 ? req1_a : req0_a;
        b_d     = g1 ? req1_b : req0_b;
        cin_d   = g1 ? req1_cin : req0_cin;
        id_d    = g1;
        k_d     = '0;
        state_d = ADD;
      end
      ADD: begin
        sum_d[4*k_q +: 4] = ad_s;
        carry_d           = ad_c;
        k_d               = k_q + 1'b1;
        if (k_q == KW'(NIB - 1)) begin
          k_d     = '0;
          state_d = RESP;
        end
      end
      RESP: if (rsp_ready) begin
        state_d = IDLE;
        prio_d  = !id_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      id_q    <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      prio_q  <= prio_d;
    end
  end

  assign rsp_valid = state_q == RESP;
  assign busy      = state_q != IDLE;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = carry_q;
  assign rsp_id    = id_q;
endmodule

// File: tb/tb_csa_share_sched.sv
// tb_csa_share_sched: directed and random checks of the shared-adder scheduler
// against a transaction-level model (a+b+cin, round-robin, fixed latency).
module tb_csa_share_sched;
  localparam int W = 16;
  localparam int NIB = W / 4;

  logic clk = 0, rst_n = 0;
  logic req0_valid = 0, req0_ready, req0_cin = 0;
  logic req1_valid = 0, req1_ready, req1_cin = 0;
  logic [W-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0, rsp_sum;
  logic rsp_valid, rsp_ready = 0, rsp_id, rsp_cout, busy;

  csa_share_sched #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { bit id; logic [W-1:0] sum; bit cout; } op_t;
  op_t exp_q[$];
  bit  m_busy, m_prio;
  int  m_left, n_chk, n_pass, n_resp, cyc_n;
  int  g_id[$], g_cyc[$];
  logic [W-1:0] last_sum;
  bit last_cout, last_id;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
  endtask

  function automatic op_t mk(input bit id, input logic [W-1:0] a, b, input bit cin);
    logic [W:0] t;
    t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    mk.id = id; mk.sum = t[W-1:0]; mk.cout = t[W];
  endfunction

  task automatic cyc(input bit v0, input logic [W-1:0] a0, b0, input bit c0,
                     input bit v1, input logic [W-1:0] a1, b1, input bit c1, input bit rr);
    bit e0, e1;
    @(negedge clk);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_cin = c0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_cin = c1;
    rsp_ready = rr;
    #1;
    e0 = !m_busy && v0 && (!v1 || !m_prio);
    e1 = !m_busy && v1 && (!v0 || m_prio);
    chk("req0_ready", req0_ready, e0);
    chk("req1_ready", req1_ready, e1);
    chk("busy", busy, m_busy);
    chk("rsp_valid", rsp_valid, m_busy && m_left == 0);
    if (m_busy && m_left == 0 && exp_q.size() > 0) begin
      chk("rsp_sum", rsp_sum, exp_q[0].sum);
      chk("rsp_cout", rsp_cout, exp_q[0].cout);
      chk("rsp_id", rsp_id, exp_q[0].id);
    end
    if (req0_ready && v0) begin g_id.push_back(0); g_cyc.push_back(cyc_n); end
    if (req1_ready && v1) begin g_id.push_back(1); g_cyc.push_back(cyc_n); end
    if (e0 || e1) begin
      exp_q.push_back(e1 ? mk(1, a1, b1, c1) : mk(0, a0, b0, c0));
      m_busy = 1; m_left = NIB;
    end else if (m_busy && m_left > 0) m_left--;
    else if (m_busy && rr) begin
      last_sum = rsp_sum; last_cout = rsp_cout; last_id = rsp_id;
      if (exp_q.size() > 0) begin m_prio = !exp_q[0].id; void'(exp_q.pop_front()); end
      m_busy = 0; n_resp++;
    end
    cyc_n++;
  endtask

  task automatic idle(input int n, input bit rr);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, rr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_outs", {rsp_sum, rsp_cout, rsp_id, req0_ready, req1_ready}, 0);
    exp_q.delete(); m_busy = 0; m_prio = 0; m_left = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    int base, lim;
    do_reset();
    // single add on requester 0, latency enforced by the model
    cyc(1, 16'h1234, 16'h0FFF, 0, 0, 0, 0, 0, 1);
    idle(NIB + 1, 1);
    chk("t1_sum", last_sum, 16'h2233);
    chk("t1_cout", last_cout, 0);
    chk("t1_id", last_id, 0);
    // full carry chain through every nibble
    cyc(0, 0, 0, 0, 1, 16'hFFFF, 16'h0000, 1, 1);
    idle(NIB + 1, 1);
    chk("t2_sum", last_sum, 16'h0000);
    chk("t2_cout", last_cout, 1);
    chk("t2_id", last_id, 1);
    cyc(1, 16'hFFFF, 16'hFFFF, 1, 0, 0, 0, 0, 1);
    idle(NIB + 1, 1);
    chk("t3_sum", last_sum, 16'hFFFF);
    chk("t3_cout", last_cout, 1);
    // arbitration from reset: alternating grants every NIB+2 cycles
    do_reset();
    g_id.delete(); g_cyc.delete();
    for (int i = 0; i < 4 * (NIB + 2); i++)
      cyc(1, 16'(i), 16'h1111, 0, 1, 16'(i * 3), 16'h2222, 1, 1);
    chk("arb_count", g_id.size(), 4);
    for (int i = 0; i < g_id.size() && i < 4; i++) begin
      chk("arb_id", g_id[i], i % 2);
      if (i > 0) chk("arb_interval", g_cyc[i] - g_cyc[i-1], NIB + 2);
    end
    idle(NIB + 2, 1);
    // back-pressure: hold rsp_ready low 5 cycles in RESP
    cyc(1, 16'hABCD, 16'h1357, 1, 0, 0, 0, 0, 0);
    idle(NIB, 0);
    idle(5, 0);
    chk("bp_busy", busy, 1);
    chk("bp_readys", {req0_ready, req1_ready}, 0);
    base = n_resp;
    idle(1, 1);
    chk("bp_done", n_resp - base, 1);
    chk("bp_sum", last_sum, 16'hABCD + 16'h1357 + 16'h1);
    idle(1, 1);
    // reset during nibble 2 of an operation
    cyc(0, 0, 0, 0, 1, 16'h0F0F, 16'h0101, 0, 1);
    idle(2, 1);
    chk("mid_busy", busy, 1);
    do_reset();
    idle(NIB + 2, 1);
    g_id.delete(); g_cyc.delete();
    cyc(1, 16'h0001, 16'h0002, 0, 1, 16'h0003, 16'h0004, 0, 1);
    chk("post_rst_grant", g_id.size() > 0 ? g_id[0] : 9, 0);
    idle(NIB + 1, 1);
    // random regression
    base = n_resp;
    lim = 0;
    while (n_resp - base < 200 && lim < 20000) begin
      cyc($urandom_range(0, 9) < 7, W'($urandom), W'($urandom), 1'($urandom),
          $urandom_range(0, 9) < 7, W'($urandom), W'($urandom), 1'($urandom),
          $urandom_range(0, 9) < 6);
      lim++;
    end
    chk("rand_responses", n_resp - base >= 200, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  always @(negedge clk) if (rst_n && req0_ready && req1_ready) chk("both_ready", 1, 0);
endmodule

// File: doc/csa_share_sched.md
# csa_share_sched

Time-shared scheduler for one 4-bit carry-skip adder slice. Two requesters submit WIDTH-bit additions over valid/ready handshakes, and a round-robin arbiter grants one at a time. The block then drives the single internal 4-bit carry-skip adder nibble by nibble, LSB first, chaining the carry through a register, and returns the full sum with the requester ID on a response handshake. It sits between operand-producing logic and the adder datapath, so wide additions reuse a single slice instead of replicating it.

## Interface
- WIDTH, 16: operand/sum width; must be a multiple of 4, minimum 4.
- NIB, WIDTH/4: derived nibble count (localparam, not overridable).

- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_cin  in  1  requester 0 carry-in.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as requester 0, for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_id  out  1  requester that issued the result (0/1).
- rsp_sum  out  WIDTH  (a + b + cin) mod 2^WIDTH.
- rsp_cout  out  1  carry out of the MSB nibble.
- busy  out  1  high in ADD and RESP.

## Operation
- One internal carry-skip adder instance (4-bit a, b, cin → 4-bit sum, carry). It is the only arithmetic resource; no other adders on the data path.
- FSM states: IDLE, ADD, RESP.
- IDLE:
  - Grant goes to the valid requester. If both are valid, grant follows the priority pointer `prio`.
  - `reqN_ready` is asserted combinationally only for the granted requester, and only in IDLE.
  - On `valid && ready`, latch a, b, cin and id; clear the nibble index k to 0; go to ADD.
- ADD, one nibble per cycle:
  - Adder inputs: a[4k+3:4k], b[4k+3:4k], and cin. For k=0, cin is the latched cin; otherwise it is `carry_reg`.
  - Write the adder sum into sum_reg[4k+3:4k] and the adder carry into `carry_reg`; increment k.
  - After nibble NIB-1, go to RESP.
- RESP:
  - `rsp_valid` = 1.
  - `rsp_sum`, `rsp_cout` and `rsp_id` come from registers and stay stable until the handshake.
  - On `rsp_valid && rsp_ready`: go to IDLE and set `prio` to the requester not just served.
- `prio` updates only on a completed response, so a granted requester cannot be starved by the other one.
- Requesters are not required to hold valid while waiting. The block does not depend on operand stability after acceptance.
- Reset: asynchronous, takes effect immediately.
  - State IDLE, `prio`=0, k=0.
  - All outputs 0: `rsp_valid`, `rsp_sum`, `rsp_cout`, `rsp_id`, `busy`, `req0_ready`, `req1_ready`.
  - Reset during ADD or RESP discards the operation; no response is ever issued for it.

## Timing
- Acceptance at edge T. ADD occupies cycles T..T+NIB-1, and `rsp_valid` is high from edge T+NIB. For WIDTH=16, the response appears 4 cycles after acceptance.
- Back-pressure: RESP lasts 1 + (cycles with `rsp_ready` low).
- The next grant happens at the earliest in the IDLE cycle after the response handshake. Minimum issue interval is NIB+2 cycles.
- No combinational path from `rsp_ready` to `rsp_*` outputs.
- `reqN_ready` depends combinationally on state, `prio` and both valids.
- Simultaneous valid in IDLE: only one ready is ever high. `req0_ready && req1_ready` is never true.
- `busy` = (state != IDLE). Both readys are 0 whenever `busy`=1.

## Test plan
- Single add, requester 0:
  - Stimulus: req0 a=0x1234, b=0x0FFF, cin=0.
  - Response: `rsp_valid` exactly 4 cycles after the accept edge, sum=0x2233, cout=0, id=0.
- Full carry chain:
  - Stimulus: req1 a=0xFFFF, b=0x0000, cin=1.
  - Response: sum=0x0000, cout=1, id=1.
  - Separately, a=0xFFFF, b=0xFFFF, cin=1 gives sum=0xFFFF, cout=1.
- Arbitration from reset:
  - Stimulus: both valid continuously, `rsp_ready`=1.
  - Response: grants alternate id 0, 1, 0, 1. Never two readys in one cycle. Issue interval 6 cycles.
- Back-pressure:
  - Stimulus: `rsp_ready` held low 5 cycles in RESP.
  - Response: `rsp_valid`, `rsp_sum`, `rsp_id` stable; `busy`=1; both readys 0. Completes on the first `rsp_ready`=1 cycle, then IDLE.
- Reset mid-operation:
  - Stimulus: `rst_n` low during ADD nibble 2.
  - Response: all outputs 0 immediately. After release, no `rsp_valid` for the aborted op. With both valid, req0 is granted first.
- Random regression:
  - Stimulus: 200 random operations on both ports with random `rsp_ready`.
  - Response: every response matches the reference model (a+b+cin) for the correct id, in grant order.
